// File: rtl/top_pkg.sv
// Shared flash-subsystem types: page width, region count and memory-protection
// region descriptors used by the flash arbiter.
package top_pkg;

    localparam int MpRegions  = 8;
    localparam int FlashPageW = 9;

    // Size is one bit wider than the page so a region can span the whole array.
    typedef struct packed {
        logic [FlashPageW-1:0] base;
        logic [FlashPageW:0]   size;
    } mp_region_cfg_t;

    typedef struct packed {
        logic en;
        logic rd;
        logic prog;
        logic erase;
    } mp_region_attr_t;

    typedef enum logic [1:0] {
        READ  = 2'd0,
        PROG  = 2'd1,
        ERASE = 2'd2,
        RSVD  = 2'd3
    } flash_op_e;

endpackage

// File: rtl/flash_mp_lookup.sv
// Combinational memory-protection lookup: lowest-index matching region supplies
// the attributes, otherwise the default entry at index MpRegions applies.
module flash_mp_lookup
    import top_pkg::*;
#(
    parameter int MpRegions = top_pkg::MpRegions
) (
    input  mp_region_cfg_t  [MpRegions:0] cfg,
    input  mp_region_attr_t [MpRegions:0] attr,
    input  logic [1:0]                    op,
    input  logic [FlashPageW-1:0]         addr,
    output logic                          allowed
);

    logic [MpRegions-1:0] hit;
    mp_region_attr_t      sel;
    logic                 unused_dflt;

    // End of region is computed two bits wider than the page so it never wraps.
    always_comb begin
        hit = '0;
        for (int i = 0; i < MpRegions; i++) begin
            hit[i] = attr[i].en && (cfg[i].size != '0)
                  && ({2'b00, addr} >= {2'b00, cfg[i].base})
                  && ({2'b00, addr} < ({2'b00, cfg[i].base} + {1'b0, cfg[i].size}));
        end
    end

    always_comb begin
        sel = attr[MpRegions];
        for (int i = MpRegions - 1; i >= 0; i--) begin
            if (hit[i]) sel = attr[i];
        end
    end

    always_comb begin
        allowed = 1'b0;
        case (flash_op_e'(op))
            READ:    allowed = sel.rd;
            PROG:    allowed = sel.prog;
            ERASE:   allowed = sel.erase;
            default: allowed = 1'b0;
        endcase
    end

    // The default entry has no meaningful base/size and is always enabled.
    assign unused_dflt = ^{cfg[MpRegions], attr[MpRegions].en};

endmodule

// File: rtl/flash_mp_arb.sv
// Round-robin arbiter for the HW/SW flash requesters with memory-protection check.
// Optional ISSUE watchdog enabled by defining FLASH_MP_ARB_TIMEOUT_EN.
module flash_mp_arb
    import top_pkg::*;
#(
    parameter int MpRegions     = top_pkg::MpRegions,
    parameter int TimeoutCycles = 1024
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [1:0]                      req_i,
    input  logic [1:0][1:0]                 op_i,
    input  logic [1:0][FlashPageW-1:0]      addr_i,
    output logic [1:0]                      gnt_o,
    output logic [1:0]                      done_o,
    output logic                            err_o,
    output logic                            timeout_o,
    input  mp_region_cfg_t  [MpRegions:0]   region_cfg_i,
    input  mp_region_attr_t [MpRegions:0]   region_attr_i,
    output logic                            flash_req_o,
    output logic [1:0]                      flash_op_o,
    output logic [FlashPageW-1:0]           flash_addr_o,
    input  logic                            flash_ack_i
);

    typedef enum logic [1:0] {IDLE, CHECK, ISSUE, ERROR} state_e;

    state_e state, state_nxt;
    logic   rr_ptr, win, win_q;
    logic   allowed, expired;

    // Sole requester wins outright; on contention the preferred one does.
    assign win = (&req_i) ? rr_ptr : req_i[1];

    flash_mp_lookup #(.MpRegions(MpRegions)) u_lookup (
        .cfg     (region_cfg_i),
        .attr    (region_attr_i),
        .op      (flash_op_o),
        .addr    (flash_addr_o),
        .allowed (allowed)
    );

`ifdef FLASH_MP_ARB_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles + 1);
    logic [CntW-1:0] cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                          cnt <= '0;
        else if (state == CHECK)                              cnt <= '0;
        else if (state == ISSUE && !flash_ack_i && !expired)  cnt <= cnt + 1'b1;
    end

    assign expired = (cnt == CntW'(TimeoutCycles));
`else
    logic unused_timeout;
    assign expired        = 1'b0;
    assign unused_timeout = ^TimeoutCycles;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            rr_ptr       <= 1'b0;
            win_q        <= 1'b0;
            flash_op_o   <= '0;
            flash_addr_o <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && |req_i) begin
                win_q        <= win;
                rr_ptr       <= ~win;
                flash_op_o   <= op_i[win];
                flash_addr_o <= addr_i[win];
            end
        end
    end

    // The CHECK->ISSUE/ERROR transition is the registered lookup result.
    always_comb begin
        state_nxt   = state;
        gnt_o       = '0;
        done_o      = '0;
        err_o       = 1'b0;
        timeout_o   = 1'b0;
        flash_req_o = 1'b0;
        case (state)
            IDLE: begin
                if (|req_i) begin
                    gnt_o[win] = rst_ni;
                    state_nxt  = CHECK;
                end
            end
            CHECK: state_nxt = allowed ? ISSUE : ERROR;
            ISSUE: begin
                flash_req_o = ~expired;
                if (flash_ack_i) begin
                    done_o[win_q] = 1'b1;
                    state_nxt     = IDLE;
                end else if (expired) begin
                    done_o[win_q] = 1'b1;
                    err_o         = 1'b1;
                    timeout_o     = 1'b1;
                    state_nxt     = IDLE;
                end
            end
            ERROR: begin
                done_o[win_q] = 1'b1;
                err_o         = 1'b1;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_flash_mp_arb.sv
// Directed bench for flash_mp_arb: arbitration order, protection lookup,
// boundaries, reset mid-command and (when built with it) the ISSUE timeout.
module tb_flash_mp_arb;
    import top_pkg::*;

    localparam int NR = MpRegions;
    localparam int TO = 16;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [1:0]            req = '0;
    logic [1:0][1:0]       op_v = '0;
    logic [1:0][8:0]       addr_v = '0;
    logic [1:0]            gnt, done;
    logic                  err, tmo;
    mp_region_cfg_t  [NR:0] cfg;
    mp_region_attr_t [NR:0] attr;
    logic                  flash_req;
    logic [1:0]            flash_op;
    logic [8:0]            flash_addr;
    logic                  ack = 1'b0;

    int n_run = 0;
    int n_fail = 0;

    flash_mp_arb #(.MpRegions(NR), .TimeoutCycles(TO)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_i         (req),
        .op_i          (op_v),
        .addr_i        (addr_v),
        .gnt_o         (gnt),
        .done_o        (done),
        .err_o         (err),
        .timeout_o     (tmo),
        .region_cfg_i  (cfg),
        .region_attr_i (attr),
        .flash_req_o   (flash_req),
        .flash_op_o    (flash_op),
        .flash_addr_o  (flash_addr),
        .flash_ack_i   (ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_regions();
        for (int i = 0; i <= NR; i++) begin
            cfg[i]  = '0;
            attr[i] = '0;
        end
    endtask

    // Issue one command from requester r; ack at once when it is expected to pass.
    task automatic run_cmd(input int r, input logic [1:0] op, input logic [8:0] a,
                           input bit exp_err, input string tag);
        req[r] = 1'b1; op_v[r] = op; addr_v[r] = a;
        #1;
        chk({tag, ".gnt"}, gnt, 32'(2'b01 << r));
        tick();
        req = '0;
        #1;
        chk({tag, ".check"}, {flash_req, done}, 0);
        tick();
        if (exp_err) begin
            chk({tag, ".rej"}, {flash_req, err, done}, {1'b0, 1'b1, 2'(2'b01 << r)});
            tick();
        end else begin
            chk({tag, ".issue"}, {flash_req, flash_addr}, {1'b1, a});
            ack = 1'b1;
            #1;
            chk({tag, ".done"}, {err, done}, {1'b0, 2'(2'b01 << r)});
            tick();
            ack = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        clear_regions();
        // reset: grant suppressed even with both requesting
        req = 2'b11;
        #12;
        chk("rst.out", {gnt, done, err, tmo, flash_req, flash_addr}, 0);
        req = '0;
        tick();
        rst_n = 1'b1;
        tick();

        // basic read, ack 3 cycles after flash_req rises
        cfg[0].base = 9'h000; cfg[0].size = 10'h020;
        attr[0].en = 1'b1; attr[0].rd = 1'b1;
        req = 2'b01; op_v[0] = 2'd0; addr_v[0] = 9'h010;
        #1;
        chk("t1.gnt", gnt, 2'b01);
        tick();
        req = '0;
        #1;
        chk("t1.n1", {flash_req, done}, 0);
        tick();
        chk("t1.n2", {flash_req, flash_op, flash_addr}, {1'b1, 2'd0, 9'h010});
        tick(); tick();
        chk("t1.n4", {flash_req, done}, {1'b1, 2'b00});
        tick();
        ack = 1'b1;
        #1;
        chk("t1.ack", {err, done}, {1'b0, 2'b01});
        tick();
        ack = 1'b0;
        #1;
        chk("t1.after", {flash_req, done}, 0);

        // round-robin alternation from a fresh reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        clear_regions();
        attr[NR] = '{en: 1'b1, rd: 1'b1, prog: 1'b1, erase: 1'b1};
        op_v = '0; addr_v[0] = 9'h0A0; addr_v[1] = 9'h0B1;
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr%0d.gnt", k), gnt, 32'(2'b01 << (k % 2)));
            tick(); tick();
            chk($sformatf("rr%0d.addr", k), {flash_req, flash_addr},
                {1'b1, (k % 2 == 1) ? 9'h0B1 : 9'h0A0});
            ack = 1'b1;
            #1;
            chk($sformatf("rr%0d.done", k), done, 32'(2'b01 << (k % 2)));
            tick();
            ack = 1'b0;
        end
        req = '0;

        // overlapping regions: lowest index wins
        clear_regions();
        attr[NR] = '{en: 1'b1, rd: 1'b1, prog: 1'b1, erase: 1'b1};
        cfg[2].base = 9'h100; cfg[2].size = 10'h040;
        attr[2] = '{en: 1'b1, rd: 1'b1, prog: 1'b0, erase: 1'b1};
        cfg[5].base = 9'h100; cfg[5].size = 10'h040;
        attr[5] = '{en: 1'b1, rd: 1'b1, prog: 1'b1, erase: 1'b1};
        run_cmd(0, 2'd1, 9'h120, 1'b1, "ovl2");
        attr[2].en = 1'b0;
        run_cmd(1, 2'd1, 9'h120, 1'b0, "ovl5");

        // boundaries, default region and reserved op
        clear_regions();
        cfg[0].base = 9'h1F0; cfg[0].size = 10'h3FF;
        attr[0] = '{en: 1'b1, rd: 1'b1, prog: 1'b1, erase: 1'b1};
        cfg[1].base = 9'h100; cfg[1].size = 10'h020;
        attr[1] = '{en: 1'b1, rd: 1'b1, prog: 1'b0, erase: 1'b0};
        run_cmd(0, 2'd0, 9'h1FF, 1'b0, "bnd_top");
        run_cmd(0, 2'd0, 9'h1EF, 1'b1, "bnd_dflt");
        run_cmd(0, 2'd0, 9'h11F, 1'b0, "bnd_last");
        run_cmd(0, 2'd0, 9'h120, 1'b1, "bnd_end");
        run_cmd(1, 2'd3, 9'h1FF, 1'b1, "op3");

        // reset while ISSUE is active; rr_ptr is 1 going into reset
        attr[NR] = '{en: 1'b1, rd: 1'b1, prog: 1'b1, erase: 1'b1};
        req = 2'b01; op_v[0] = 2'd0; addr_v[0] = 9'h055;
        tick();
        req = '0;
        tick();
        chk("rst_mid.issue", flash_req, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid.out", {flash_req, done, err, flash_op, flash_addr}, 0);
        tick(); tick();
        rst_n = 1'b1;
        req = 2'b11; addr_v[1] = 9'h066;
        #1;
        chk("rst_mid.gnt", gnt, 2'b01);
        tick();
        req = '0;
        tick();
        chk("rst_mid.addr", {flash_req, flash_addr}, {1'b1, 9'h055});
        ack = 1'b1;
        #1;
        chk("rst_mid.done", done, 2'b01);
        tick();
        ack = 1'b0;

`ifdef FLASH_MP_ARB_TIMEOUT_EN
        // watchdog: no ack for TO cycles after ISSUE entry
        req = 2'b10; op_v[1] = 2'd0; addr_v[1] = 9'h077;
        tick();
        req = '0;
        tick();
        chk("to.entry", {flash_req, done}, {1'b1, 2'b00});
        repeat (TO - 1) tick();
        chk("to.pre", {flash_req, done, tmo}, {1'b1, 2'b00, 1'b0});
        tick();
        chk("to.fire", {flash_req, done, err, tmo}, {1'b0, 2'b10, 1'b1, 1'b1});
        tick();
        ack = 1'b1;
        #1;
        chk("to.late_ack", {flash_req, done, err, tmo}, 0);
        tick();
        ack = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
